key_schedule: RTL and testbench
===============================

# key_schedule

Iterative AES-128 key-schedule sequencer. It accepts a 128-bit cipher key on a start pulse and generates round keys 1–10, one round per two clocks, through a single-round expansion stage with a registered S-box. All 11 round keys are held in an internal buffer, and the buffer is served to the cipher datapath's AddRoundKey stage through a registered read port. It sits between the key input register and the round-controller / AddRoundKey logic.

## Interface
- NR, 10, number of rounds; only 10 (AES-128) is supported, and elaboration fails otherwise.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle request to expand `key`; sampled in IDLE and DONE only.
- key  in  128  cipher key; byte 0 = key[127:120]; w0 = key[127:96].
- busy  out  1  high while expansion is in progress.
- done  out  1  high from completion until the next accepted start or reset.
- rd_round  in  4  round-key index 0..10.
- rd_key  out  128  round key for the rd_round sampled on the previous edge.
- rev  in  1  present only with KEYSCHED_REVERSE_EN (see Configuration).

## Operation
- FSM states: IDLE, SUB, GEN, DONE. Reset state is IDLE.
- IDLE/DONE with start=1:
  - write key into entry 0 and into the prev register;
  - round ← 1;
  - done ← 0, busy ← 1;
  - next state SUB.
- SUB:
  - present RotWord(w3 of prev) to the S-box; the result registers on this edge;
  - next state GEN.
- GEN:
  - w4 = w0 ^ SubWord(RotWord(w3)) ^ Rcon[round];
  - w5 = w1 ^ w4; w6 = w2 ^ w5; w7 = w3 ^ w6;
  - write {w4,w5,w6,w7} to entry[round] and to prev.
  - If round==10: next state DONE, done ← 1, busy ← 0.
  - Otherwise: round ← round+1, next state SUB.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 in the top byte, low 24 bits zero.
- start in SUB/GEN is ignored; the run is not restarted.
- A new start in DONE overwrites all entries in order; entries not yet rewritten keep the old key's values.
- Read port:
  - rd_key ← entry[rd_round] on every edge, regardless of state;
  - rd_round 11..15 gives rd_key = 0.
- Reads of an entry on the same edge it is written return the old contents (read-before-write).

## Timing
- Reset values:
  - busy = 0, done = 0, rd_key = 0;
  - all 11 entries = 0, prev = 0, round = 0;
  - S-box output register = 0.
- Start accepted at edge E0 (entry 0 written at E0).
- Round r is written at edge E0 + 2r. Entry 10 is written at E0+20.
- busy is high in the cycles after E0 through E0+20; done rises on E0+20.
- Read latency is 1 cycle: rd_round applied before edge N gives rd_key valid after edge N.
- Entry r is readable with the correct value from the request sampled at edge E0+2r+1 onward.
- Reset asserted mid-run returns to IDLE immediately (asynchronous). All entries clear; no partial keys remain.

## Configuration
- KEYSCHED_REVERSE_EN defined:
  - the rev input port exists;
  - when rev=1 the read address is 10 − rd_round, giving decryption ordering. Out-of-range rd_round (11..15) still returns 0.
- KEYSCHED_REVERSE_EN undefined:
  - no rev port;
  - direct addressing only.

## Structure
- Shared package aes_pkg holds:
  - the state enum (IDLE, SUB, GEN, DONE);
  - the Rcon constant array [1:10];
  - typedefs word_t (32 b) and block_t (128 b);
  - localparam NR_AES128 = 10.
- One sub-module, key_round_gen:
  - one-round expansion, with the S-box registered inside;
  - inputs: prev key, round, clk; output: new key, valid one edge after prev/round are presented.
- The FSM, round counter, key buffer and read port live in the top level.

## Test plan
- Reset, then read rd_round 0..10 → rd_key = 0 for all; busy = 0, done = 0.
- Expansion with key 2b7e1516 28aed2a6 abf71588 09cf4f3c:
  - entry1 = a0fafe17 88542cb1 23a33939 2a6c7605;
  - entry10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6;
  - done rises exactly 20 edges after start.
- start pulsed again at E0+6 during a run → ignored; the final entries match the first key; done timing is unchanged.
- Reset asserted at E0+9 → all outputs and entries are 0 immediately. A subsequent start with the same key yields the same results as the clean expansion run.
- rd_round = 12 → rd_key = 0. With KEYSCHED_REVERSE_EN defined, rev=1 and rd_round=0 → rd_key = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- start in DONE with key 00…00:
  - done drops the next cycle;
  - entry1 becomes 62636363 62636363 62636363 62636363;
  - done returns after 20 edges.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and byte-substitution helpers.
// The S-box is computed as GF(2^8) inversion followed by the AES affine map.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    GEN  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  localparam int NR_AES128 = 10;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      if (aa[7]) aa = {aa[6:0], 1'b0} ^ 8'h1b;
      else       aa = {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] t3, t7, t15, t31, t63, t127;
    t3   = gf_mul(gf_mul(x, x), x);
    t7   = gf_mul(gf_mul(t3, t3), x);
    t15  = gf_mul(gf_mul(t7, t7), x);
    t31  = gf_mul(gf_mul(t15, t15), x);
    t63  = gf_mul(gf_mul(t31, t31), x);
    t127 = gf_mul(gf_mul(t63, t63), x);
    return gf_mul(t127, t127);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
           {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic word_t rcon_word(input logic [3:0] round);
    if (round >= 4'd1 && round <= 4'd10) return {RCON[round], 24'h000000};
    else                                 return 32'h00000000;
  endfunction

endpackage

// File: rtl/key_round_gen.sv
// One AES-128 key-expansion round. SubWord(RotWord(w3)) is registered, so the
// new round key is valid one edge after prev/round are presented.
module key_round_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  block_t     prev,
  input  logic [3:0] round,
  output block_t     new_key
);

  word_t sub_r;
  word_t w4_s, w5_s, w6_s, w7_s;

  // Registered S-box stage on w3 of the previous round key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sub_r <= 32'h00000000;
    else       sub_r <= sub_word(rot_word(prev[31:0]));
  end

  // Word chaining for the new round key.
  always_comb begin
    w4_s    = prev[127:96] ^ sub_r ^ rcon_word(round);
    w5_s    = prev[95:64] ^ w4_s;
    w6_s    = prev[63:32] ^ w5_s;
    w7_s    = prev[31:0]  ^ w6_s;
    new_key = {w4_s, w5_s, w6_s, w7_s};
  end

endmodule

// File: rtl/key_schedule.sv
// Iterative AES-128 key-schedule sequencer with an 11-entry round-key buffer
// and registered read port. Optional macro KEYSCHED_REVERSE_EN adds the rev port.
module key_schedule
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  block_t       key,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rd_round,
`ifdef KEYSCHED_REVERSE_EN
  input  logic         rev,
`endif
  output block_t       rd_key
);

  if (NR != NR_AES128) begin : g_bad_nr
    $error("key_schedule: only NR=10 (AES-128) is supported");
  end

  state_t     state_r, state_next_s;
  logic [3:0] round_r;
  block_t     prev_r;
  block_t     entries_r [0:10];
  block_t     new_key_s;
  logic       load_s, gen_s, last_s;
  logic [3:0] addr_s;
  logic       in_range_s;

  key_round_gen u_round_gen (
    .clk     (clk),
    .reset   (reset),
    .prev    (prev_r),
    .round   (round_r),
    .new_key (new_key_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // FSM next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) state_next_s = SUB;
        else       state_next_s = state_r;
      end
      SUB:     state_next_s = GEN;
      GEN: begin
        if (round_r == 4'd10) state_next_s = DONE;
        else                  state_next_s = SUB;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM control decodes.
  always_comb begin
    load_s = 1'b0;
    gen_s  = 1'b0;
    case (state_r)
      IDLE, DONE: load_s = start;
      GEN:        gen_s  = 1'b1;
      SUB:        gen_s  = 1'b0;
      default:    gen_s  = 1'b0;
    endcase
    last_s = gen_s && (round_r == 4'd10);
  end

  // Round counter, chaining register and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      round_r <= 4'd0;
      prev_r  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (load_s) begin
      round_r <= 4'd1;
      prev_r  <= key;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else if (last_s) begin
      prev_r  <= new_key_s;
      busy    <= 1'b0;
      done    <= 1'b1;
    end else if (gen_s) begin
      round_r <= round_r + 4'd1;
      prev_r  <= new_key_s;
    end
  end

  // Round-key buffer; entry 0 takes the cipher key, entry[round] the new key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= 10; i++) entries_r[i] <= '0;
    end else if (load_s) begin
      entries_r[0] <= key;
    end else if (gen_s) begin
      entries_r[round_r] <= new_key_s;
    end
  end

  // Read address mapping; reverse order serves decryption.
  always_comb begin
    in_range_s = (rd_round <= 4'd10);
`ifdef KEYSCHED_REVERSE_EN
    if (rev) addr_s = 4'd10 - rd_round;
    else     addr_s = rd_round;
`else
    addr_s = rd_round;
`endif
  end

  // Registered read port; same-edge writes are not visible until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           rd_key <= '0;
    else if (in_range_s) rd_key <= entries_r[addr_s];
    else                 rd_key <= '0;
  end

endmodule

// File: tb/tb_key_schedule.sv
// Directed, table-driven bench for key_schedule (FIPS-197 key plus all-zero key).
module tb_key_schedule;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  block_t     key;
  logic       busy, done;
  logic [3:0] rd_round;
  block_t     rd_key;
`ifdef KEYSCHED_REVERSE_EN
  logic       rev = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] rnd;
    block_t     exp;
  } vec_t;
  vec_t tbl [11];

  localparam block_t KEY_A = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam block_t KEY_Z = 128'h0;

  key_schedule dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .key      (key),
    .busy     (busy),
    .done     (done),
    .rd_round (rd_round),
`ifdef KEYSCHED_REVERSE_EN
    .rev      (rev),
`endif
    .rd_key   (rd_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic read_check(input logic [3:0] r, input block_t exp, input string nm);
    rd_round = r;
    @(posedge clk);
    @(negedge clk);
    chk(nm, rd_key, exp);
  endtask

  // Launch: start sampled on the next posedge (E0); returns at the following negedge.
  task automatic do_start(input block_t k);
    @(negedge clk);
    start = 1'b1;
    key   = k;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges after E0 until done; an optional second start at E0+inj is ignored.
  task automatic wait_done(input int inj, output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == inj - 1) begin
        start = 1'b1;
        key   = KEY_Z;
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic check_table_a(input string tag);
    for (int i = 0; i < 11; i++)
      read_check(tbl[i].rnd, tbl[i].exp, $sformatf("%s_entry%0d", tag, i));
  endtask

  int n;

  initial begin
    tbl[0]  = '{4'd0,  128'h2b7e1516_28aed2a6_abf71588_09cf4f3c};
    tbl[1]  = '{4'd1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605};
    tbl[2]  = '{4'd2,  128'hf2c295f2_7a96b943_5935807a_7359f67f};
    tbl[3]  = '{4'd3,  128'h3d80477d_4716fe3e_1e237e44_6d7a883b};
    tbl[4]  = '{4'd4,  128'hef44a541_a8525b7f_b671253b_db0bad00};
    tbl[5]  = '{4'd5,  128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc};
    tbl[6]  = '{4'd6,  128'h6d88a37a_110b3efd_dbf98641_ca0093fd};
    tbl[7]  = '{4'd7,  128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f};
    tbl[8]  = '{4'd8,  128'head27321_b58dbad2_312bf560_7f8d292f};
    tbl[9]  = '{4'd9,  128'hac7766f3_19fadc21_28d12941_575c006e};
    tbl[10] = '{4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6};

    reset = 1'b1; start = 1'b0; key = '0; rd_round = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("reset_busy", {127'd0, busy}, 128'd0);
    chk("reset_done", {127'd0, done}, 128'd0);
    for (int i = 0; i <= 10; i++)
      read_check(i[3:0], 128'h0, $sformatf("reset_entry%0d", i));

    // Clean expansion.
    do_start(KEY_A);
    chk("busy_after_start", {127'd0, busy}, 128'd1);
    wait_done(-1, n);
    chk("done_latency", n, 20);
    chk("busy_at_done", {127'd0, busy}, 128'd0);
    check_table_a("run1");
    read_check(4'd12, 128'h0, "oob_rd12");
    read_check(4'd15, 128'h0, "oob_rd15");
`ifdef KEYSCHED_REVERSE_EN
    rev = 1'b1;
    read_check(4'd0, tbl[10].exp, "rev_rd0");
    read_check(4'd10, tbl[0].exp, "rev_rd10");
    read_check(4'd12, 128'h0, "rev_oob");
    rev = 1'b0;
`endif

    // Second start at E0+6 must be ignored.
    do_start(KEY_A);
    wait_done(6, n);
    chk("ignored_start_latency", n, 20);
    read_check(4'd1, tbl[1].exp, "ignored_entry1");
    read_check(4'd10, tbl[10].exp, "ignored_entry10");

    // Async reset at E0+9.
    do_start(KEY_A);
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_busy", {127'd0, busy}, 128'd0);
    chk("midreset_done", {127'd0, done}, 128'd0);
    chk("midreset_rdkey", rd_key, 128'h0);
    @(negedge clk);
    reset = 1'b0;
    read_check(4'd0, 128'h0, "midreset_entry0");
    read_check(4'd3, 128'h0, "midreset_entry3");
    read_check(4'd10, 128'h0, "midreset_entry10");
    do_start(KEY_A);
    wait_done(-1, n);
    chk("rerun_latency", n, 20);
    check_table_a("rerun");

    // Restart from DONE with the zero key; old entries survive until rewritten.
    rd_round = 4'd5;
    do_start(KEY_Z);
    chk("restart_done_drop", {127'd0, done}, 128'd0);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 2) begin
        chk("restart_old_entry5", rd_key, tbl[5].exp);
        rd_round = 4'd1;
      end else if (n == 3) begin
        chk("restart_entry1_early", rd_key, 128'h62636363_62636363_62636363_62636363);
      end
    end
    chk("restart_latency", n, 20);
    read_check(4'd1, 128'h62636363_62636363_62636363_62636363, "zero_entry1");
    read_check(4'd2, 128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa, "zero_entry2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
